// File: rtl/motor_step_pkg.sv
// Shared channel FSM state encoding and queue-level width for the step generator.
package motor_step_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DSETUP = 3'd1,
    ST_PRE    = 3'd2,
    ST_PULSE  = 3'd3,
    ST_POST   = 3'd4
  } state_t;

  localparam int QDEPTH_DEF = 4;
  localparam int LVL_W      = $clog2(QDEPTH_DEF) + 1;

endpackage

// File: rtl/motor_step_chan.sv
// One step/dir channel: strobe queue, phase FSM, down-counter and position counter.
// Strobe into an empty idle channel leaves IDLE one edge later; a full queue drops the strobe and flags missed.
module motor_step_chan
  import motor_step_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int POS_W  = 32,
  parameter int QDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CNT_W-1:0]        pre_n,
  input  logic [CNT_W-1:0]        pulse_n,
  input  logic [CNT_W-1:0]        post_n,
  input  logic [CNT_W-1:0]        dir_setup_n,
  input  logic                    step_stb,
  input  logic                    step_dir,
  input  logic                    set_x,
  input  logic signed [POS_W-1:0] x_val,
  output logic                    step,
  output logic                    dir,
  output logic                    missed,
  output logic                    busy,
  output logic [$clog2(QDEPTH):0] q_level,
  output logic signed [POS_W-1:0] x
);

  localparam int AW = $clog2(QDEPTH);
  localparam int LW = $clog2(QDEPTH) + 1;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [QDEPTH-1:0]         mem_q, mem_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]             level_q, level_d;
  logic                      dir_q, dir_d, step_q, step_d, missed_q, missed_d;
  logic signed [POS_W-1:0]   x_q, x_d;
  logic                      q_full, q_empty, push, pop, pop_dir;
  logic [CNT_W-1:0]          pulse_len;

  // Fullness is judged on the registered level, so a same-cycle pop cannot make room.
  assign q_full    = (level_q == LW'(QDEPTH));
  assign q_empty   = (level_q == '0);
  assign push      = step_stb && !q_full;
  assign pop       = (state_q == ST_IDLE) && !q_empty;
  assign pop_dir   = mem_q[rd_ptr_q];
  assign pulse_len = (pulse_n == '0) ? CNT_W'(1) : pulse_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      missed_q <= 1'b0;
      x_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      missed_q <= missed_d;
      x_q      <= x_d;
    end
  end

  // Each phase loads its length on entry and ends when the counter reaches 1; zero-length phases are skipped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          if ((pop_dir != dir_q) && (dir_setup_n != '0)) begin
            state_d = ST_DSETUP;
            cnt_d   = dir_setup_n;
          end else if (pre_n != '0) begin
            state_d = ST_PRE;
            cnt_d   = pre_n;
          end else begin
            state_d = ST_PULSE;
            cnt_d   = pulse_len;
          end
        end
      end
      ST_DSETUP: begin
        if (cnt_q == CNT_W'(1)) begin
          if (pre_n != '0) begin
            state_d = ST_PRE;
            cnt_d   = pre_n;
          end else begin
            state_d = ST_PULSE;
            cnt_d   = pulse_len;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PRE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_PULSE;
          cnt_d   = pulse_len;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == CNT_W'(1)) begin
          if (post_n != '0) begin
            state_d = ST_POST;
            cnt_d   = post_n;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_POST: begin
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = step_dir;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
    missed_d = step_stb && q_full;
    dir_d    = pop ? pop_dir : dir_q;
    x_d      = x_q;
    // A load wins over the step count of a coincident pop.
    if (set_x)    x_d = x_val;
    else if (pop) x_d = pop_dir ? (x_q - POS_W'(1)) : (x_q + POS_W'(1));
  end

  always_comb begin
    step_d = (state_d == ST_PULSE);
  end

  assign step    = step_q;
  assign dir     = dir_q;
  assign missed  = missed_q;
  assign busy    = (state_q != ST_IDLE) || !q_empty;
  assign q_level = level_q;
  assign x       = x_q;

endmodule

// File: rtl/motor_step_gen_multi.sv
// Multi-channel step/dir generator: N_CH independent channels sharing one timing profile.
// Adds a global hold that snapshots every channel's pre-edge position in the same cycle.
module motor_step_gen_multi
  import motor_step_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  parameter int POS_W  = 32,
  parameter int QDEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CNT_W-1:0]                     pre_n,
  input  logic [CNT_W-1:0]                     pulse_n,
  input  logic [CNT_W-1:0]                     post_n,
  input  logic [CNT_W-1:0]                     dir_setup_n,
  input  logic [N_CH-1:0]                      step_stb,
  input  logic [N_CH-1:0]                      step_dir,
  output logic [N_CH-1:0]                      step,
  output logic [N_CH-1:0]                      dir,
  output logic [N_CH-1:0]                      missed,
  output logic [N_CH-1:0]                      busy,
  output logic [N_CH*($clog2(QDEPTH)+1)-1:0]   q_level,
  input  logic [N_CH-1:0]                      set_x,
  input  logic signed [POS_W-1:0]              x_val,
  output logic [N_CH*POS_W-1:0]                x,
  input  logic                                 hold,
  output logic [N_CH*POS_W-1:0]                x_hold
);

  localparam int LW = $clog2(QDEPTH) + 1;

  logic [N_CH*POS_W-1:0] x_hold_q, x_hold_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    motor_step_chan #(
      .CNT_W  (CNT_W),
      .POS_W  (POS_W),
      .QDEPTH (QDEPTH)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .pre_n       (pre_n),
      .pulse_n     (pulse_n),
      .post_n      (post_n),
      .dir_setup_n (dir_setup_n),
      .step_stb    (step_stb[i]),
      .step_dir    (step_dir[i]),
      .set_x       (set_x[i]),
      .x_val       (x_val),
      .step        (step[i]),
      .dir         (dir[i]),
      .missed      (missed[i]),
      .busy        (busy[i]),
      .q_level     (q_level[i*LW +: LW]),
      .x           (x[i*POS_W +: POS_W])
    );
  end

  always_comb begin
    x_hold_d = hold ? x : x_hold_q;
  end

  always_ff @(posedge clk) begin
    if (reset) x_hold_q <= '0;
    else       x_hold_q <= x_hold_d;
  end

  assign x_hold = x_hold_q;

endmodule

// File: doc/motor_step_gen_multi.md
Name: motor_step_gen_multi

Overview:
- Parametrised successor to the single-channel step/dir pulse generator.
- Drives N_CH independent step/dir outputs from one shared timing profile.
- Adds a per-channel step queue, so strobes arriving mid-pulse are buffered rather than lost, and a direction-setup delay inserted on direction reversal.
- Signed position counters per channel with per-channel load and a global simultaneous snapshot (hold) for coherent multi-axis position capture.
- Sits between the motion planner's step-strobe outputs and the stepper driver pins.

Parameters:
- N_CH, 4: number of motor channels.
- CNT_W, 16: width of timing inputs and phase counters.
- POS_W, 32: width of signed position counters.
- QDEPTH, 4: step-queue depth per channel, power of 2, >=2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pre_n  in  CNT_W  cycles step low before pulse.
- pulse_n  in  CNT_W  cycles step high; 0 is treated as 1.
- post_n  in  CNT_W  cycles step low after pulse.
- dir_setup_n  in  CNT_W  extra cycles inserted after a direction change, before PRE.
- step_stb  in  N_CH  per-channel step request, one step per cycle high.
- step_dir  in  N_CH  direction qualifying step_stb (1 = negative).
- step  out  N_CH  registered step pulses.
- dir  out  N_CH  registered direction pins.
- missed  out  N_CH  one-cycle pulse: strobe dropped because queue full.
- busy  out  N_CH  channel not IDLE or queue non-empty.
- q_level  out  N_CH*($clog2(QDEPTH)+1)  per-channel queue occupancy.
- set_x  in  N_CH  per-channel position load.
- x_val  in  POS_W  signed load value, shared.
- x  out  N_CH*POS_W  signed positions; channel i at [i*POS_W +: POS_W].
- hold  in  1  snapshot all positions.
- x_hold  out  N_CH*POS_W  snapshot positions.

Behaviour:
- Reset: all outputs 0, queues empty, states IDLE, counters 0. Reset mid-pulse drops step at the next edge.
- Per-channel FSM states: IDLE, DSETUP, PRE, PULSE, POST.
- Queue push: on step_stb, judged on registered level. level==QDEPTH means missed=1 next cycle and the strobe is dropped, even if a pop occurs the same cycle.
- Pop:
  - Occurs in IDLE when level>0.
  - At the pop edge, dir <= popped dir and x <= x-1 (dir=1) or x+1 (dir=0), wrapping two's complement.
  - Next state is the first non-zero phase in order: DSETUP (only if popped dir != previous dir and dir_setup_n>0), then PRE, then PULSE.
  - Simultaneous push and pop: level unchanged.
- Phase counter: a down-counter loaded from the current input value at phase entry. Input changes affect only later phases. Zero-length phases are skipped. POST end or skip returns to IDLE.
- step = 1 exactly while state==PULSE, registered.
- Latency: strobe sampled at edge t into an empty IDLE channel leaves IDLE at t+1. step rises at t+1+pre_n (no dir change) and stays high max(pulse_n,1) cycles.
- Step period: 1 + dsetup + pre_n + max(pulse_n,1) + post_n.
- Same-cycle priorities:
  - set_x overrides pop update.
  - hold captures pre-edge x of all channels in the same cycle.
  - hold and set_x together: x_hold gets old x.
- Channels are fully independent except for shared timing inputs and hold.

Decomposition:
- Package motor_step_pkg: state enum constants ST_IDLE..ST_POST, and localparam LVL_W = $clog2(QDEPTH)+1.
- Sub-module motor_step_chan: one channel's queue, FSM, counter and position. Instantiated N_CH times by generate. The top contains only the hold snapshot and port packing.

Test Plan:
- pre=2, pulse=3, post=1, dsetup=0; ch0 strobe dir=0 at edge 10 -> step0 high edges 13..15; x0=1 from edge 11; busy0 low from edge 17.
- Same timing; ch1 strobes dir=0 on 6 consecutive cycles, QDEPTH=4 -> first strobe pops immediately, next 4 queue, 6th gives missed1 pulse; exactly 5 pulses; x1=5.
- dsetup=5; ch2 steps dir=0 then dir=1 -> second pulse delayed by 5 extra cycles; dir2 flips at second pop edge; x2 returns to 0.
- set_x ch3 with x_val=-100 on the same cycle as a pop -> x3=-100. Then hold -> x_hold3=-100 and all other channels captured coherently.
- Assert reset while step0 high -> step0=0, q_level0=0, x0=0 next edge; strobe in the reset cycle is ignored.
- pulse_n=0, pre=0, post=0; continuous strobes -> step high 1 cycle every 2 cycles, missed asserted once the queue fills.
